// File: rtl/result_fifo.sv
// Valid/ready FIFO that buffers results from the upstream AND stage.
// It reports occupancy and keeps a sticky flag for words offered while the buffer is full.
module result_fifo #(
  parameter int N     = 4,
  parameter int DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         IN_valid,
  input  logic [N-1:0]                 IN_data,
  input  logic                         IN_ready,
  input  logic                         IN_clrDrop,
  output logic                         OUT_ready,
  output logic                         OUT_valid,
  output logic [N-1:0]                 OUT_data,
  output logic [$clog2(DEPTH+1)-1:0]   OUT_count,
  output logic                         OUT_drop
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [N-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          drop_q, drop_d;
  logic          push, pop;

  assign OUT_ready = (count_q != CW'(DEPTH));
  assign OUT_valid = (count_q != '0);
  assign OUT_data  = OUT_valid ? mem_q[rd_ptr_q] : '0;
  assign OUT_count = count_q;
  assign OUT_drop  = drop_q;

  // A full buffer refuses the push even when a pop frees a slot in the same cycle.
  assign push = IN_valid & OUT_ready;
  assign pop  = OUT_valid & IN_ready;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    drop_d   = drop_q;
    if (push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
    // A new drop takes priority over a clear request.
    if (IN_valid && !OUT_ready) drop_d = 1'b1;
    else if (IN_clrDrop)        drop_d = 1'b0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      drop_q   <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      drop_q   <= drop_d;
    end
  end

  // Storage has no reset, so the array can map onto distributed RAM.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= IN_data;
  end

endmodule

// File: tb/tb_result_fifo.sv
// Directed and randomized checks of result_fifo.
// The reference model is a word queue plus a sticky drop bit.
module tb_result_fifo;
  localparam int N     = 4;
  localparam int DEPTH = 4;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         IN_valid = 1'b0;
  logic [N-1:0] IN_data = '0;
  logic         IN_ready = 1'b0;
  logic         IN_clrDrop = 1'b0;
  logic         OUT_ready, OUT_valid, OUT_drop;
  logic [N-1:0] OUT_data;
  logic [$clog2(DEPTH+1)-1:0] OUT_count;

  logic [N-1:0] q[$];
  logic         m_drop = 1'b0;
  int           total = 0;
  int           passed = 0;
  int           fails = 0;

  result_fifo #(.N(N), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .IN_valid(IN_valid), .IN_data(IN_data),
    .IN_ready(IN_ready), .IN_clrDrop(IN_clrDrop), .OUT_ready(OUT_ready),
    .OUT_valid(OUT_valid), .OUT_data(OUT_data), .OUT_count(OUT_count),
    .OUT_drop(OUT_drop)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_state(input string tag);
    logic [N-1:0] exp_data;
    exp_data = (q.size() != 0) ? q[0] : '0;
    chk({tag, ".valid"}, 32'(OUT_valid), 32'(q.size() != 0));
    chk({tag, ".ready"}, 32'(OUT_ready), 32'(q.size() != DEPTH));
    chk({tag, ".count"}, 32'(OUT_count), 32'(q.size()));
    chk({tag, ".data"},  32'(OUT_data),  32'(exp_data));
    chk({tag, ".drop"},  32'(OUT_drop),  32'(m_drop));
  endtask

  // Drives one cycle and updates the model from the pre-edge occupancy.
  task automatic step(input string tag, input logic v, input logic [N-1:0] d,
                      input logic r, input logic c);
    logic full, empty, do_push, do_pop;
    IN_valid = v; IN_data = d; IN_ready = r; IN_clrDrop = c;
    full    = (q.size() == DEPTH);
    empty   = (q.size() == 0);
    do_push = v && !full;
    do_pop  = r && !empty;
    @(posedge clk);
    if (v && full) m_drop = 1'b1;
    else if (c)    m_drop = 1'b0;
    if (do_pop)  void'(q.pop_front());
    if (do_push) q.push_back(d);
    #1;
    $display("%s v=%b d=%h r=%b c=%b -> count=%0d valid=%b data=%h drop=%b",
             tag, v, d, r, c, OUT_count, OUT_valid, OUT_data, OUT_drop);
    check_state(tag);
  endtask

  initial begin
    // 1: reset then idle
    #12;
    chk("t1.rst_valid", 32'(OUT_valid), 32'd0);
    chk("t1.rst_ready", 32'(OUT_ready), 32'd1);
    chk("t1.rst_count", 32'(OUT_count), 32'd0);
    chk("t1.rst_data",  32'(OUT_data),  32'd0);
    chk("t1.rst_drop",  32'(OUT_drop),  32'd0);
    rst = 1'b1;
    @(posedge clk); #1;
    step("t1.idle", 1'b0, 4'h0, 1'b0, 1'b0);

    // 2: two words held, then drained in order
    step("t2.pushA", 1'b1, 4'hA, 1'b0, 1'b0);
    step("t2.push5", 1'b1, 4'h5, 1'b0, 1'b0);
    chk("t2.count2", 32'(OUT_count), 32'd2);
    chk("t2.headA",  32'(OUT_data),  32'hA);
    step("t2.popA", 1'b0, 4'h0, 1'b1, 1'b0);
    chk("t2.head5", 32'(OUT_data), 32'h5);
    step("t2.pop5", 1'b0, 4'h0, 1'b1, 1'b0);
    chk("t2.empty", 32'(OUT_valid), 32'd0);

    // 3: fill, overflow drop, clear
    for (int i = 0; i < DEPTH; i++) step("t3.fill", 1'b1, 4'(i + 2), 1'b0, 1'b0);
    chk("t3.full_ready", 32'(OUT_ready), 32'd0);
    chk("t3.full_count", 32'(OUT_count), 32'd4);
    step("t3.overflowF", 1'b1, 4'hF, 1'b0, 1'b0);
    chk("t3.drop_set", 32'(OUT_drop), 32'd1);
    step("t3.clr", 1'b0, 4'h0, 1'b0, 1'b1);
    chk("t3.drop_clr", 32'(OUT_drop), 32'd0);

    // 5: full with pop and push together -> pop only, push dropped
    step("t5.popfull", 1'b1, 4'hE, 1'b1, 1'b0);
    chk("t5.count3", 32'(OUT_count), 32'd3);
    chk("t5.drop",   32'(OUT_drop),  32'd1);
    for (int i = 0; i < 3; i++) step("t5.drain", 1'b0, 4'h0, 1'b1, 1'b1);
    chk("t5.empty", 32'(OUT_valid), 32'd0);

    // 4: streaming 1..9 with the consumer always ready
    for (int i = 1; i <= 9; i++) begin
      step("t4.stream", 1'b1, 4'(i), 1'b1, 1'b0);
      chk("t4.count1", 32'(OUT_count), 32'd1);
      chk("t4.latency", 32'(OUT_data), 32'(i));
    end
    step("t4.tail", 1'b0, 4'h0, 1'b1, 1'b0);

    // 6: asynchronous reset with three words stored
    for (int i = 0; i < 3; i++) step("t6.fill", 1'b1, 4'(i + 8), 1'b0, 1'b0);
    IN_valid = 1'b0;
    #2 rst = 1'b0;
    #1;
    q.delete();
    m_drop = 1'b0;
    chk("t6.async_count", 32'(OUT_count), 32'd0);
    chk("t6.async_valid", 32'(OUT_valid), 32'd0);
    check_state("t6.in_reset");
    @(negedge clk) rst = 1'b1;
    @(posedge clk); #1;
    step("t6.push", 1'b1, 4'h6, 1'b0, 1'b0);
    chk("t6.first", 32'(OUT_data), 32'h6);
    step("t6.pop", 1'b0, 4'h0, 1'b1, 1'b0);

    // Random traffic: fill-biased, then drain-biased
    for (int i = 0; i < 400; i++) begin
      logic rv, rr, rc;
      rv = ($urandom_range(3) != 0);
      rr = (i < 200) ? ($urandom_range(2) == 0) : ($urandom_range(2) != 0);
      rc = ($urandom_range(7) == 0);
      step("rnd", rv, 4'($urandom), rr, rc);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
